pd_stream: RTL and testbench

PD_STREAM -- requirements
Module: pd_stream

---
 rtl/pd_stream.sv | 213 +++++++++++++++++++++
 tb/tb_pd_stream.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pd_stream.sv
// Streaming divisibility / primality checker: bit-serial mod-DIVISOR scan, then optional trial division.
// Define PD_PRIME_EN to compile in the primality engine; otherwise out_prime is tied to 0.
module pd_stream #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_div,
    output logic             out_prime,
    output logic             busy
);
    localparam int RW = $clog2(DIVISOR);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [RW:0] DIV_C = (RW + 1)'(DIVISOR);

    typedef enum logic [2:0] {
        IDLE,
        DIV_SCAN,
`ifdef PD_PRIME_EN
        PRIME_CHK,
        TRIAL_CMP,
        TRIAL_DIV,
`endif
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    r_q, r_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_div_q, out_div_d;
    logic [RW:0]      r_nx;
    logic             fin;
    logic             fin_div;
    logic             fin_prime;
    logic             last_bit;

`ifdef PD_PRIME_EN
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] trem_q, trem_d;
    logic             div_flag_q, div_flag_d;
    logic             out_prime_q, out_prime_d;
    logic [WIDTH+1:0] d_ext;
    logic [WIDTH+1:0] sq;
    logic [WIDTH:0]   t_nx;
`endif

    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        out_data_d = out_data_q;
        out_div_d  = out_div_q;
        fin        = 1'b0;
        fin_div    = 1'b0;
        fin_prime  = 1'b0;
        last_bit   = (cnt_q == CW'(WIDTH - 1));

        // one step of r = (2r + bit) mod DIVISOR; 2r+bit < 2*DIVISOR so one subtract suffices
        r_nx = {r_q, sh_q[WIDTH-1]};
        if (r_nx >= DIV_C) r_nx = r_nx - DIV_C;

`ifdef PD_PRIME_EN
        d_d         = d_q;
        trem_d      = trem_q;
        div_flag_d  = div_flag_q;
        out_prime_d = out_prime_q;
        d_ext       = {2'b00, d_q};
        sq          = d_ext * d_ext;
        t_nx        = {trem_q, sh_q[WIDTH-1]};
        if (t_nx >= {1'b0, d_q}) t_nx = t_nx - {1'b0, d_q};
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    val_d   = in_data;
                    sh_d    = in_data;
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = DIV_SCAN;
                end
            end
            DIV_SCAN: begin
                sh_d  = sh_q << 1;
                r_d   = r_nx[RW-1:0];
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
`ifdef PD_PRIME_EN
                    div_flag_d = (r_nx == '0);
                    state_d    = PRIME_CHK;
`else
                    fin     = 1'b1;
                    fin_div = (r_nx == '0);
`endif
                end
            end
`ifdef PD_PRIME_EN
            PRIME_CHK: begin
                fin_div = div_flag_q;
                if (val_q < WIDTH'(2)) begin
                    fin = 1'b1;
                end else if (val_q == WIDTH'(2) || val_q == WIDTH'(3)) begin
                    fin       = 1'b1;
                    fin_prime = 1'b1;
                end else if (!val_q[0]) begin
                    fin = 1'b1;
                end else begin
                    d_d     = WIDTH'(3);
                    state_d = TRIAL_CMP;
                end
            end
            TRIAL_CMP: begin
                fin_div = div_flag_q;
                if (sq > {2'b00, val_q}) begin
                    fin       = 1'b1;
                    fin_prime = 1'b1;
                end else begin
                    sh_d    = val_q;
                    trem_d  = '0;
                    cnt_d   = '0;
                    state_d = TRIAL_DIV;
                end
            end
            TRIAL_DIV: begin
                fin_div = div_flag_q;
                sh_d    = sh_q << 1;
                trem_d  = t_nx[WIDTH-1:0];
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    if (t_nx == '0) begin
                        fin = 1'b1;
                    end else begin
                        d_d     = d_q + WIDTH'(2);
                        state_d = TRIAL_CMP;
                    end
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // results are only published on DONE entry so outputs hold between operations
        if (fin) begin
            out_data_d = val_q;
            out_div_d  = fin_div;
`ifdef PD_PRIME_EN
            out_prime_d = fin_prime;
`endif
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            val_q      <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            r_q        <= '0;
            out_data_q <= '0;
            out_div_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            out_data_q <= out_data_d;
            out_div_q  <= out_div_d;
        end
    end

`ifdef PD_PRIME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            trem_q      <= '0;
            div_flag_q  <= 1'b0;
            out_prime_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            trem_q      <= trem_d;
            div_flag_q  <= div_flag_d;
            out_prime_q <= out_prime_d;
        end
    end
    assign out_prime = out_prime_q;
`else
    assign out_prime = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_div   = out_div_q;

endmodule

// File: tb/tb_pd_stream.sv
// Randomized bench for pd_stream against an arithmetic reference model (WIDTH=8, DIVISOR=3).
module tb_pd_stream;
    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_div;
    logic         out_prime;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;
    int prev_data = 0, prev_div = 0, prev_prime = 0;

    pd_stream #(.WIDTH(W), .DIVISOR(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_div(out_div), .out_prime(out_prime),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // divisibility, primality and latency straight from the arithmetic rules
    function automatic void model(input int v, output int div, output int prime, output int lat);
        div = (v % D == 0) ? 1 : 0;
`ifdef PD_PRIME_EN
        if (v < 2) begin
            prime = 0; lat = W + 2;
        end else if (v == 2 || v == 3) begin
            prime = 1; lat = W + 2;
        end else if (v % 2 == 0) begin
            prime = 0; lat = W + 2;
        end else begin
            int d, k;
            d = 3; k = 0; prime = 1; lat = 0;
            while (d * d <= v) begin
                k++;
                if (v % d == 0) begin
                    prime = 0;
                    lat = W + 2 + k * (W + 1);
                    break;
                end
                d += 2;
            end
            if (prime == 1) lat = W + 3 + k * (W + 1);
        end
`else
        prime = 0;
        lat = W + 1;
`endif
    endfunction

    // called at a negedge; returns at a negedge one cycle after the output handshake
    task automatic run_op(input int v, input int stall);
        int ed, ep, el, c;
        model(v, ed, ep, el);
        c = 0;
        while (!in_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("in_ready_before", int'(in_ready), 1);
        out_ready = (stall == 0);
        in_valid = 1'b1;
        in_data = W'(v);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = W'($urandom);
        c = 1;
        chk("busy", int'(busy), 1);
        chk("hold_data", int'(out_data), prev_data);
        chk("hold_div", int'(out_div), prev_div);
        while (!out_valid && c < 400) begin
            @(negedge clk);
            in_data = W'($urandom);
            c++;
        end
        chk($sformatf("latency(%0d)", v), c, el);
        chk($sformatf("data(%0d)", v), int'(out_data), v);
        chk($sformatf("div(%0d)", v), int'(out_div), ed);
        chk($sformatf("prime(%0d)", v), int'(out_prime), ep);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), v);
            chk("stall_div", int'(out_div), ed);
            chk("stall_prime", int'(out_prime), ep);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        chk("hs_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("post_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
        prev_data = v; prev_div = ed; prev_prime = ep;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_div"}, int'(out_div), 0);
        chk({tag, "_out_prime"}, int'(out_prime), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #1;
        chk_reset_state("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 0);
        run_op(13, 0);
        run_op(9, 0);
        run_op(251, 0);
        run_op(255, 0);
        run_op(2, 5);
        run_op(1, 0);
        run_op(3, 2);
        run_op(4, 0);

        // reset in the middle of a long operation
        in_valid = 1'b1;
        in_data = W'(251);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        prev_data = 0; prev_div = 0; prev_prime = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(6, 0);

        for (int n = 0; n < 40; n++)
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
